// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: parametrised VGA timing generator with a
// frame-synchronous test-pattern engine, pixel-tick and frame-start strobes.
// Optional build macro: VGA_BORDER_EN forces a one-pixel all-ones border
// around the visible area, overriding the selected pattern.
module vga_timing_pattern_gen #(
    parameter int G_H_RES    = 640,
    parameter int G_H_FP     = 16,
    parameter int G_H_SYNC   = 96,
    parameter int G_H_BP     = 48,
    parameter int G_V_RES    = 480,
    parameter int G_V_FP     = 10,
    parameter int G_V_SYNC   = 2,
    parameter int G_V_BP     = 33,
    parameter int G_H_POL    = 0,
    parameter int G_V_POL    = 0,
    parameter int G_CLK_DIV  = 1,
    parameter int G_R_W      = 3,
    parameter int G_G_W      = 3,
    parameter int G_B_W      = 2,
    parameter int G_CHK_LOG2 = 5,
    localparam int H_TOT = G_H_RES + G_H_FP + G_H_SYNC + G_H_BP,
    localparam int V_TOT = G_V_RES + G_V_FP + G_V_SYNC + G_V_BP,
    localparam int CW    = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    output logic             o_h_sync,
    output logic             o_v_sync,
    output logic [G_R_W-1:0] o_r,
    output logic [G_G_W-1:0] o_g,
    output logic [G_B_W-1:0] o_b,
    output logic             o_active,
    output logic [CW-1:0]    o_x,
    output logic [CW-1:0]    o_y,
    output logic             o_pix_tick,
    output logic             o_frame_start
);

    localparam int DW = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(G_CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(G_H_RES);
    localparam logic [CW-1:0] V_VIS    = CW'(G_V_RES);
    localparam logic [CW-1:0] H_SS     = CW'(G_H_RES + G_H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(G_H_RES + G_H_FP + G_H_SYNC);
    localparam logic [CW-1:0] V_SS     = CW'(G_V_RES + G_V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(G_V_RES + G_V_FP + G_V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [CW-1:0] H_EDGE   = CW'(G_H_RES - 1);
    localparam logic [CW-1:0] V_EDGE   = CW'(G_V_RES - 1);
`endif
    localparam logic H_ON = (G_H_POL != 0);
    localparam logic V_ON = (G_V_POL != 0);

    // Elaboration-time parameter sanity checks
    if (G_CLK_DIV < 1) begin : g_bad_div
        $error("G_CLK_DIV must be >= 1");
    end
    if (G_H_FP < 1 || G_H_SYNC < 1 || G_H_BP < 1 ||
        G_V_FP < 1 || G_V_SYNC < 1 || G_V_BP < 1) begin : g_bad_porch
        $error("porch and sync widths must be >= 1");
    end
    if (G_CHK_LOG2 >= CW) begin : g_bad_chk
        $error("G_CHK_LOG2 must be below the counter width");
    end

    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    logic [1:0]       mode_q;
    logic             pix_adv;
    logic             line_end;
    logic             frame_first;

    logic [1:0]       mode_eff;
    logic [2:0]       bar;
    logic             active_d;
    logic             h_sync_d;
    logic             v_sync_d;
    logic [G_R_W-1:0] r_d;
    logic [G_G_W-1:0] g_d;
    logic [G_B_W-1:0] b_d;

    assign pix_adv     = (div_cnt == DIV_LAST);
    assign line_end    = pix_adv && (h_cnt == H_LAST);
    assign frame_first = (div_cnt == '0) && (h_cnt == '0) && (v_cnt == '0);

    // Pixel divider, raster counters and frame-synchronous mode latch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            mode_q  <= '0;
        end else begin
            div_cnt <= pix_adv ? '0 : div_cnt + DW'(1);
            if (pix_adv) begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + CW'(1);
            end
            if (line_end) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
            end
            if (frame_first) begin
                mode_q <= i_mode;
            end
        end
    end

    // Timing decode and pattern generation from the current counters.
    // On the latch clock the incoming mode is used directly so that pixel
    // (0,0) already shows the newly selected pattern.
    always_comb begin
        mode_eff = frame_first ? i_mode : mode_q;
        active_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        h_sync_d = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? H_ON : !H_ON;
        v_sync_d = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? V_ON : !V_ON;

        bar = '0;
        for (int unsigned j = 1; j < 8; j++) begin
            if (h_cnt >= CW'((j * G_H_RES + 7) / 8)) begin
                bar = 3'(j);
            end
        end

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active_d) begin
            case (mode_eff)
                2'd0: begin
                    r_d = '1;
                    g_d = '1;
                    b_d = '1;
                end
                2'd1: begin
                    r_d = {G_R_W{bar[2]}};
                    g_d = {G_G_W{bar[1]}};
                    b_d = {G_B_W{bar[0]}};
                end
                2'd2: begin
                    if (h_cnt[G_CHK_LOG2] ^ v_cnt[G_CHK_LOG2]) begin
                        r_d = '1;
                        g_d = '1;
                        b_d = '1;
                    end
                end
                default: begin
                    r_d = G_R_W'(h_cnt >> G_CHK_LOG2);
                    g_d = G_G_W'(v_cnt >> G_CHK_LOG2);
                end
            endcase
`ifdef VGA_BORDER_EN
            if ((h_cnt == '0) || (h_cnt == H_EDGE) ||
                (v_cnt == '0) || (v_cnt == V_EDGE)) begin
                r_d = '1;
                g_d = '1;
                b_d = '1;
            end
`endif
        end
    end

    // Output registers: one clock behind the counters, all mutually aligned
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_h_sync      <= !H_ON;
            o_v_sync      <= !V_ON;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_pix_tick    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_h_sync      <= h_sync_d;
            o_v_sync      <= v_sync_d;
            o_r           <= r_d;
            o_g           <= g_d;
            o_b           <= b_d;
            o_active      <= active_d;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_pix_tick    <= (div_cnt == '0);
            o_frame_start <= frame_first;
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Self-checking bench: default-timing instance (A), reduced-timing instance
// (B) for frame-level behaviour, and a divide-by-4 positive-hsync instance (C).
module tb_vga_timing_pattern_gen;

    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [1:0] mode_a, mode_b, mode_c;

    logic       a_hs, a_vs, a_act, a_pt, a_fs;
    logic [2:0] a_r, a_g;
    logic [1:0] a_b;
    logic [9:0] a_x, a_y;

    logic       b_hs, b_vs, b_act, b_pt, b_fs;
    logic [2:0] b_r, b_g;
    logic [1:0] b_b;
    logic [6:0] b_x, b_y;

    logic       c_hs, c_vs, c_act, c_pt, c_fs;
    logic [2:0] c_r, c_g;
    logic [1:0] c_b;
    logic [9:0] c_x, c_y;

    vga_timing_pattern_gen u_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_mode(mode_a),
        .o_h_sync(a_hs), .o_v_sync(a_vs), .o_r(a_r), .o_g(a_g), .o_b(a_b),
        .o_active(a_act), .o_x(a_x), .o_y(a_y),
        .o_pix_tick(a_pt), .o_frame_start(a_fs)
    );

    // 64x48 visible, H_TOT = 80, V_TOT = 55, frame = 4400 clocks
    vga_timing_pattern_gen #(
        .G_H_RES(64), .G_H_FP(4), .G_H_SYNC(8), .G_H_BP(4),
        .G_V_RES(48), .G_V_FP(2), .G_V_SYNC(2), .G_V_BP(3),
        .G_CHK_LOG2(3)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_mode(mode_b),
        .o_h_sync(b_hs), .o_v_sync(b_vs), .o_r(b_r), .o_g(b_g), .o_b(b_b),
        .o_active(b_act), .o_x(b_x), .o_y(b_y),
        .o_pix_tick(b_pt), .o_frame_start(b_fs)
    );

    vga_timing_pattern_gen #(
        .G_CLK_DIV(4), .G_H_POL(1)
    ) u_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_mode(mode_c),
        .o_h_sync(c_hs), .o_v_sync(c_vs), .o_r(c_r), .o_g(c_g), .o_b(c_b),
        .o_active(c_act), .o_x(c_x), .o_y(c_y),
        .o_pix_tick(c_pt), .o_frame_start(c_fs)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x; int y; int r; int g; int b; int act;
    } pix_t;

    typedef struct {
        int mode; int x; int y; int r; int g; int b; int act;
    } vec_t;

    pix_t sb[$];
    vec_t vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_x(input int w);
        if (w == 0) return int'(a_x);
        return int'(b_x);
    endfunction
    function automatic int get_y(input int w);
        if (w == 0) return int'(a_y);
        return int'(b_y);
    endfunction
    function automatic int get_r(input int w);
        if (w == 0) return int'(a_r);
        return int'(b_r);
    endfunction
    function automatic int get_g(input int w);
        if (w == 0) return int'(a_g);
        return int'(b_g);
    endfunction
    function automatic int get_b(input int w);
        if (w == 0) return int'(a_b);
        return int'(b_b);
    endfunction
    function automatic int get_act(input int w);
        if (w == 0) return int'(a_act);
        return int'(b_act);
    endfunction
    function automatic logic get_fs(input int w);
        if (w == 0) return a_fs;
        return b_fs;
    endfunction

    task automatic wait_fs(input int which, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_fs(which) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!get_fs(which)) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Push the expected pixel, wait for the raster to reach it, then pop and compare
    task automatic expect_pixel(input int which, input string name,
                                input int x, input int y,
                                input int r, input int g, input int b, input int act);
        pix_t e;
        int   n;
        int   hres;
        int   vres;
        hres = (which == 0) ? 640 : 64;
        vres = (which == 0) ? 480 : 48;
        e = '{x, y, r, g, b, act};
`ifdef VGA_BORDER_EN
        if (act != 0 && (x == 0 || x == hres - 1 || y == 0 || y == vres - 1)) begin
            e.r = 7;
            e.g = 7;
            e.b = 3;
        end
`endif
        sb.push_back(e);
        n = 0;
        while (!(get_x(which) == x && get_y(which) == y) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!(get_x(which) == e.x && get_y(which) == e.y)) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_r"}, 64'(get_r(which)), 64'(e.r));
            chk({name, "_g"}, 64'(get_g(which)), 64'(e.g));
            chk({name, "_b"}, 64'(get_b(which)), 64'(e.b));
            chk({name, "_act"}, 64'(get_act(which)), 64'(e.act));
        end
    endtask

    initial begin
        int hs_low, hs_first, hs_last, act_cnt, act_bad, white_bad, blank_bad, line_per;
        int tick_cnt, tick_bad, last_tick, hold_bad, last_change, c_hs_cnt, c_hs_bad;
        int per, vs_low, vs_bad, n, cur_mode;
        logic [9:0] prev_cx;

        // Pattern vectors for instance B (64x48, checker/gradient shift 3)
        vt[0]  = '{2, 0, 8, 7, 7, 3, 1};
        vt[1]  = '{2, 8, 8, 0, 0, 0, 1};
        vt[2]  = '{1, 0, 2, 0, 0, 0, 1};
        vt[3]  = '{1, 8, 2, 0, 0, 3, 1};
        vt[4]  = '{1, 24, 2, 0, 7, 3, 1};
        vt[5]  = '{1, 32, 2, 7, 0, 0, 1};
        vt[6]  = '{1, 63, 2, 7, 7, 3, 1};
        vt[7]  = '{3, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{3, 16, 24, 2, 3, 0, 1};
        vt[9]  = '{3, 63, 47, 7, 5, 0, 1};
        vt[10] = '{0, 5, 3, 7, 7, 3, 1};
        vt[11] = '{0, 70, 3, 0, 0, 0, 0};
        vt[12] = '{0, 10, 50, 0, 0, 0, 0};
        vt[13] = '{0, 40, 40, 7, 7, 3, 1};
        vt[14] = '{0, 79, 54, 0, 0, 0, 0};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;

        // Reset values
        #27;
        chk("rst_a_hs", 64'(a_hs), 64'd1);
        chk("rst_a_vs", 64'(a_vs), 64'd1);
        chk("rst_a_rgb", 64'({a_r, a_g, a_b}), 64'd0);
        chk("rst_a_act", 64'(a_act), 64'd0);
        chk("rst_a_xy", 64'({a_x, a_y}), 64'd0);
        chk("rst_a_pt", 64'(a_pt), 64'd0);
        chk("rst_a_fs", 64'(a_fs), 64'd0);
        chk("rst_c_hs", 64'(c_hs), 64'd0);

        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);
        chk("first_a_fs", 64'(a_fs), 64'd1);
        chk("first_b_fs", 64'(b_fs), 64'd1);
        chk("first_c_fs", 64'(c_fs), 64'd1);
        chk("first_c_pt", 64'(c_pt), 64'd1);
        chk("first_a_xy", 64'({a_x, a_y}), 64'd0);

        // Line 0 of A and the first line of C, sampled every clock
        hs_low = 0; hs_first = -1; hs_last = -1; act_cnt = 0; act_bad = 0;
        white_bad = 0; blank_bad = 0; line_per = 0;
        tick_cnt = 0; tick_bad = 0; last_tick = -1; hold_bad = 0; last_change = 0;
        c_hs_cnt = 0; c_hs_bad = 0; prev_cx = c_x;
        for (int i = 0; i < 3200; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 800) begin
                if (!a_hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(a_x);
                    hs_last = int'(a_x);
                end
                if (a_act) act_cnt++;
                if (a_act != (a_x < 10'd640)) act_bad++;
                if (a_act && {a_r, a_g, a_b} != 8'hFF) white_bad++;
                if (!a_act && {a_r, a_g, a_b} != 8'h00) blank_bad++;
            end
            if (i > 0 && a_x == 10'd0 && line_per == 0) line_per = i;
            if (c_pt) begin
                tick_cnt++;
                if (last_tick >= 0 && i - last_tick != 4) tick_bad++;
                last_tick = i;
            end
            if (i > 0 && c_x != prev_cx) begin
                if (i - last_change != 4) hold_bad++;
                last_change = i;
            end
            prev_cx = c_x;
            if (c_hs) begin
                c_hs_cnt++;
                if (c_x < 10'd656 || c_x > 10'd751) c_hs_bad++;
            end
        end
        chk("a_hs_low_count", 64'(hs_low), 64'd96);
        chk("a_hs_first_x", 64'(hs_first), 64'd656);
        chk("a_hs_last_x", 64'(hs_last), 64'd751);
        chk("a_active_count", 64'(act_cnt), 64'd640);
        chk("a_active_window", 64'(act_bad), 64'd0);
        chk("a_white_active", 64'(white_bad), 64'd0);
        chk("a_blank_black", 64'(blank_bad), 64'd0);
        chk("a_line_period", 64'(line_per), 64'd800);
        chk("c_tick_count", 64'(tick_cnt), 64'd800);
        chk("c_tick_spacing", 64'(tick_bad), 64'd0);
        chk("c_x_hold", 64'(hold_bad), 64'd0);
        chk("c_hs_high_count", 64'(c_hs_cnt), 64'd384);
        chk("c_hs_window", 64'(c_hs_bad), 64'd0);

        // Asynchronous reset of A in the middle of line 7
        mode_a = 2'd2;
        n = 0;
        while (!(a_x == 10'd300 && a_y == 10'd7) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("a_reach_300_7", 64'({a_x, a_y}), 64'({10'd300, 10'd7}));
        chk("a_pre_rst_white", 64'({a_r, a_g, a_b}), 64'hFF);
        rst_a = 1'b0;
        #1;
        chk("a_mid_rst_hs", 64'(a_hs), 64'd1);
        chk("a_mid_rst_rgb", 64'({a_r, a_g, a_b}), 64'd0);
        chk("a_mid_rst_act", 64'(a_act), 64'd0);
        chk("a_mid_rst_xy", 64'({a_x, a_y}), 64'd0);
        chk("a_mid_rst_pt", 64'(a_pt), 64'd0);
        repeat (3) @(negedge clk);
        chk("a_rst_hold_pt", 64'(a_pt), 64'd0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_rel_fs", 64'(a_fs), 64'd1);
        chk("a_rel_xy", 64'({a_x, a_y}), 64'd0);
        expect_pixel(0, "a_chk_0_0", 0, 0, 0, 0, 0, 1);
        expect_pixel(0, "a_chk_32_0", 32, 0, 7, 7, 3, 1);
        expect_pixel(0, "a_chk_0_5", 0, 5, 0, 0, 0, 1);

        // B: frame period and vertical sync window
        wait_fs(1, "b_fs_a");
        per = 0; vs_low = 0; vs_bad = 0;
        for (int i = 0; i <= 6000; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (b_fs) begin
                    per = i;
                    break;
                end
            end
            if (!b_vs) vs_low++;
            if (b_vs == (b_y >= 7'd50 && b_y <= 7'd51)) vs_bad++;
        end
        chk("b_frame_period", 64'(per), 64'd4400);
        chk("b_vs_low_count", 64'(vs_low), 64'd160);
        chk("b_vs_window", 64'(vs_bad), 64'd0);

        // Mid-frame mode change only takes effect at the next frame
        n = 0;
        while (b_y != 7'd20 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        mode_b = 2'd2;
        expect_pixel(1, "b_latch_hold", 8, 30, 7, 7, 3, 1);
        wait_fs(1, "b_fs_b");
        expect_pixel(1, "b_latch_0_0", 0, 0, 0, 0, 0, 1);
        expect_pixel(1, "b_latch_8_0", 8, 0, 7, 7, 3, 1);

        // Table-driven pattern vectors
        cur_mode = 2;
        for (int i = 0; i < 15; i++) begin
            if (vt[i].mode != cur_mode) begin
                cur_mode = vt[i].mode;
                mode_b = 2'(cur_mode);
                wait_fs(1, "b_fs_vec");
            end
            expect_pixel(1, $sformatf("vec%0d", i), vt[i].x, vt[i].y,
                         vt[i].r, vt[i].g, vt[i].b, vt[i].act);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
- Parametrised next-generation VGA controller.
- Generalises the fixed 640x480 / RGB332 top to arbitrary timing, configurable sync polarity, per-channel colour width and an integer pixel-clock divider.
- Adds a runtime-selectable test-pattern engine with frame-synchronous mode switching, plus pixel-tick and frame-start strobes for downstream frame-buffer logic.
- Sits at the top of the display path and drives the DAC/connector pins directly.

Parameters:
- G_H_RES, 640, visible pixels per line
- G_H_FP, 16, horizontal front porch (pixels)
- G_H_SYNC, 96, horizontal sync width (pixels)
- G_H_BP, 48, horizontal back porch (pixels)
- G_V_RES, 480, visible lines per frame
- G_V_FP, 10, vertical front porch (lines)
- G_V_SYNC, 2, vertical sync width (lines)
- G_V_BP, 33, vertical back porch (lines)
- G_H_POL, 0, h-sync asserted level (0 = active-low)
- G_V_POL, 0, v-sync asserted level
- G_CLK_DIV, 1, i_clk cycles per pixel (>=1)
- G_R_W / G_G_W / G_B_W, 3 / 3 / 2, colour channel widths
- G_CHK_LOG2, 5, log2 of checker square size; also gradient shift

Ports:
- i_clk, in, 1, system clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_mode, in, 2, pattern select: 0 white, 1 colour bars, 2 checkerboard, 3 gradient
- o_h_sync, out, 1, horizontal sync
- o_v_sync, out, 1, vertical sync
- o_r / o_g / o_b, out, G_R_W / G_G_W / G_B_W, colour
- o_active, out, 1, visible-region flag
- o_x / o_y, out, CW, current pixel coordinates
- o_pix_tick, out, 1, first i_clk of each new pixel
- o_frame_start, out, 1, first i_clk of pixel (0,0)

Behaviour:
- Totals and counter width: H_TOT = H_RES+FP+SYNC+BP, V_TOT likewise; CW = $clog2(max(H_TOT,V_TOT)).
- Reset: one clock, reset asynchronous active-low. i_rst_n low clears div_cnt, h_cnt, v_cnt and mode_q to 0. It also drives outputs to: o_h_sync = !G_H_POL, o_v_sync = !G_V_POL, colours = 0, o_active = 0, o_x = o_y = 0, o_pix_tick = 0, o_frame_start = 0.
- Divider: div_cnt counts 0..G_CLK_DIV-1 and wraps. h_cnt advances only when div_cnt == G_CLK_DIV-1. With G_CLK_DIV = 1 it advances every clock.
- Horizontal wrap: h_cnt wraps at H_TOT-1 to 0 and advances v_cnt in the same clock.
- Vertical wrap: v_cnt wraps at V_TOT-1 to 0.
- Output registration: all outputs are registered every clock from the current (div_cnt, h_cnt, v_cnt), i.e. one i_clk latency behind the counters. Sync, active, colour and coordinates are therefore mutually aligned.
- Active region: active = (h < H_RES) && (v < V_RES).
- Sync windows: h_sync = G_H_POL when H_RES+FP <= h < H_RES+FP+SYNC, else !G_H_POL. v_sync uses the same rule on v_cnt.
- Strobes:
  - o_pix_tick = registered (div_cnt == 0).
  - o_frame_start = registered (div_cnt == 0 && h == 0 && v == 0).
  - First o_frame_start occurs on the first clock edge after reset release.
- Mode latching: mode_q <= i_mode only on the clock where div_cnt == 0, h == 0, v == 0. Mid-frame changes of i_mode have no visible effect until the next frame.
- Patterns (when active):
  - Mode 0: all channels all-ones.
  - Mode 1: bar k = floor(x*8/H_RES), k in 0..7. R = all-ones if k[2], G = all-ones if k[1], B = all-ones if k[0], else 0. Compare against precomputed constant thresholds; no divider.
  - Mode 2: white if x[G_CHK_LOG2] ^ y[G_CHK_LOG2], else black.
  - Mode 3: R = low G_R_W bits of x>>G_CHK_LOG2; G = low G_G_W bits of y>>G_CHK_LOG2; B = 0.
- Blanking: when not active, all colour outputs are 0 regardless of mode.
- Reset mid-operation: outputs return to reset values immediately (asynchronously). On release, timing restarts at (0,0) and a fresh o_frame_start is issued.
- Elaboration assertions: G_CLK_DIV >= 1; all porch and sync widths >= 1; G_CHK_LOG2 < CW.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: any active pixel with x == 0, x == H_RES-1, y == 0 or y == V_RES-1 is forced to all-ones on every channel, overriding the selected pattern. Used for monitor-overscan alignment.
- Undefined: no override; the pattern is output unchanged. No port differences either way.

Test Plan:
- Horizontal timing, defaults with G_CLK_DIV = 1, mode 0:
  - o_h_sync low exactly while o_x in 656..751 (96 clocks).
  - o_active high while o_x < 640.
  - Line period 800 clocks.
- Vertical timing, defaults:
  - o_v_sync low exactly while o_y in 490..491.
  - o_frame_start period 420000 clocks.
  - White (all-ones) pixels only while o_active.
- Divider and polarity, G_CLK_DIV = 4, G_H_POL = 1:
  - o_pix_tick every 4th clock; o_x holds each value 4 clocks.
  - o_h_sync high during sync window.
  - Frame period 1680000 clocks.
- Mode latching: switch i_mode 0 -> 2 at o_y = 100:
  - Rest of frame stays white.
  - Next frame: checker with G_CHK_LOG2 = 5, so pixel (32,0) = white and (0,0) = black.
- Bars and gradient:
  - Mode 1: pixel x = 80 gives R=0, G=0, B=3; x = 560 gives 7/7/3.
  - Mode 3: pixel (64,96) gives R=2, G=3, B=0.
- Reset mid-line: assert i_rst_n low at o_x = 300, o_y = 7:
  - Outputs go to reset values immediately.
  - After release, o_frame_start on the first edge; o_x/o_y restart at 0.
  - With VGA_BORDER_EN, pixel (0,5) = all-ones in mode 2.
